conv_store_ddr_stream_ctrl: RTL and testbench
=============================================

// Module: conv_store_ddr_stream_ctrl
// PURPOSE
// Parametrised store engine that moves one output tile from the conv-core output FIFO grid into DDR.
// For each tile row it issues one DDR burst command, then streams packed DDR words over a valid/ready interface.
// New over the previous store controller:
//   - backpressure-safe output buffer
//   - zero padding of an odd channel tail
//   - parametrised FIFO grid and word widths
//   - tile-done and error pulses
// Sits between the conv-core row FIFOs and the DDR write port.
// PARAMETERS
// SA_ROW_NUM       4    FIFO groups per tile row (channel direction)
// SA_COLUMN_NUM    3    tile rows held in the FIFO grid (max cur_poy)
// ROW_NUM_IN_SA    16   channels per FIFO in mode 0; mode 1 is 2x
// CONV_WORD_W      256  one FIFO half-word: one channel's pixels
// DDR_WORD_W       512  DDR data word; must equal 2*CONV_WORD_W
// ADR_W            32   DDR word address width
// OUT_BUF_DEPTH    2    output buffer entries (>=2)
// PORTS
// clk                 in   1            clock
// reset               in   1            asynchronous, active-low reset
// start               in   1            1-cycle tile start pulse; ignored unless IDLE
// mode                in   4            0: 1 ch per FIFO read, 2 reads per DDR word; 1: 2 ch per read, 1 read per word
// layer_base_adr      in   ADR_W        layer base word address
// row_adr_shift       in   4            log2(DDR words per output row)
// cur_oy_start        in   16           tile origin, 1-based; sampled at start
// cur_ox_start        in   16           tile origin, 1-based; sampled at start
// cur_of_start        in   16           tile origin, 1-based; sampled at start
// x_word_ofs          in   16           word offset of tile x origin inside a row; sampled at start
// cur_poy             in   16           tile rows, 0..SA_COLUMN_NUM; sampled at start
// cur_pof             in   16           tile channels; sampled at start
// fifo_rds            out  SA_ROW_NUM*SA_COLUMN_NUM  one-hot FIFO read strobe
// fifo_data           in   DDR_WORD_W   selected FIFO data, valid 1 cycle after strobe
// cmd_valid           out  1            DDR command valid
// cmd_ready           in   1            DDR command ready
// cmd_adr             out  ADR_W        burst start word address
// cmd_len             out  16           burst length in DDR words
// wr_valid            out  1            DDR data valid
// wr_ready            in   1            DDR data ready
// wr_data             out  DDR_WORD_W   DDR data word
// wr_last             out  1            last word of the current burst
// out_y_idx           out  16           1-based y index of the word at the head of wr_data
// out_f_idx           out  16           1-based first channel of the word at the head of wr_data
// busy                out  1            high from IDLE exit to DONE
// tile_done           out  1            1-cycle pulse at tile end
// err                 out  1            1-cycle pulse when a start is rejected
// BEHAVIOUR
// - Reset (async, reset=0): FSM=IDLE, all counters cleared, output buffer emptied, all outputs 0.
//   An in-flight burst is abandoned.
// - Start handling:
//   - start in IDLE latches all tile inputs.
//   - Illegal start -> err pulse next cycle, stay IDLE. Illegal means any of:
//     mode>1; cur_poy>SA_COLUMN_NUM; cur_pof>SA_ROW_NUM*CH_PER_FIFO (CH_PER_FIFO=16 in mode 0, 32 in mode 1).
//   - cur_poy==0 or cur_pof==0 -> DONE directly; no command is issued.
// - FSM: IDLE -> CMD -> DATA -> (CMD | DONE) -> IDLE.
//   - DONE lasts 1 cycle and asserts tile_done.
// - CMD state:
//   - cmd_valid=1; cmd_len=L=ceil(cur_pof/2).
//   - cmd_adr = layer_base_adr + ((cur_oy_start-1+r)<<row_adr_shift) + x_word_ofs + ((cur_of_start-1)>>1), where r = 0-based row.
//   - All arithmetic is ADR_W bits, wrapping.
//   - cmd_valid&&cmd_ready -> DATA.
//   - cmd_adr and cmd_len hold stable while cmd_valid && !cmd_ready.
// - DATA state: channel counter c runs 0..cur_pof-1; FIFO select = r*SA_ROW_NUM + c/CH_PER_FIFO.
//   - Mode 1: each read supplies 2 channels = 1 DDR word.
//   - Mode 0: each read's low CONV_WORD_W bits form one channel.
//     - Even channel -> pack low half; odd channel -> high half, then push the word.
//     - Odd cur_pof: last word has its high half zero and is pushed immediately.
// - Read issue rule: a read issues only if (buffer occupancy + reads in flight that complete a word) < OUT_BUF_DEPTH.
//   Result: no FIFO word is ever dropped; stall indefinitely on wr_ready=0.
// - Output: wr_valid = buffer not empty; words leave in order.
//   - wr_data, wr_last, out_y_idx and out_f_idx stay stable while wr_valid && !wr_ready.
//   - wr_last=1 on word L of each burst.
// - Row end: when word L is accepted (wr_valid&&wr_ready&&wr_last):
//   - last row -> DONE;
//   - else r++ -> CMD.
//   - The next command is never issued before the previous burst drains.
// - Latency: first fifo_rds strobe the cycle after the cmd handshake; first wr_valid 2 cycles (mode 1) or 3 cycles (mode 0) after the handshake with wr_ready=1.
//   Full rate: 1 word/cycle (mode 1), 1 word/2 cycles (mode 0).
// - start is ignored while busy; reset mid-tile returns to IDLE with no tile_done.
// TESTING
// - Mode 1, poy=3, pof=64, oy/ox/of_start=1, row_adr_shift=4, base=0x1000, wr_ready=1:
//   3 cmds at 0x1000/0x1010/0x1020, len=32; 96 words; wr_last on words 32/64/96; tile_done once.
// - Mode 0, poy=1, pof=5:
//   cmd_len=3; words = {ch2,ch1},{ch4,ch3},{0,ch5}; FIFO 0 read 5 times.
// - Mode 1, pof=64, wr_ready toggling 1-0-0-1 and held low 20 cycles:
//   no lost or duplicated word; wr_data is stable while stalled; FIFO reads stop within OUT_BUF_DEPTH.
// - cmd_ready held low 10 cycles:
//   cmd_valid stays high with constant adr/len; no fifo_rds until the handshake.
// - Illegal starts, mode=2 or poy=4 or pof=80 in mode 0:
//   err pulse; no cmd; busy stays 0.
// - Reset pulled low mid-burst in row 2:
//   all outputs 0 immediately; after release a fresh start runs a full correct tile.

Source files
------------

// File: rtl/conv_store_ddr_stream_ctrl.sv
// Store engine: drains one output tile from the conv-core FIFO grid into DDR, one burst per row.
// Words pass through a small fall-through buffer so wr_valid never drops a word under backpressure.
module conv_store_ddr_stream_ctrl #(
  parameter int unsigned SA_ROW_NUM    = 4,
  parameter int unsigned SA_COLUMN_NUM = 3,
  parameter int unsigned ROW_NUM_IN_SA = 16,
  parameter int unsigned CONV_WORD_W   = 256,
  parameter int unsigned DDR_WORD_W    = 512,
  parameter int unsigned ADR_W         = 32,
  parameter int unsigned OUT_BUF_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [3:0]                          mode,
  input  logic [ADR_W-1:0]                    layer_base_adr,
  input  logic [3:0]                          row_adr_shift,
  input  logic [15:0]                         cur_oy_start,
  input  logic [15:0]                         cur_ox_start,
  input  logic [15:0]                         cur_of_start,
  input  logic [15:0]                         x_word_ofs,
  input  logic [15:0]                         cur_poy,
  input  logic [15:0]                         cur_pof,
  output logic [SA_ROW_NUM*SA_COLUMN_NUM-1:0] fifo_rds,
  input  logic [DDR_WORD_W-1:0]               fifo_data,
  output logic                                cmd_valid,
  input  logic                                cmd_ready,
  output logic [ADR_W-1:0]                    cmd_adr,
  output logic [15:0]                         cmd_len,
  output logic                                wr_valid,
  input  logic                                wr_ready,
  output logic [DDR_WORD_W-1:0]               wr_data,
  output logic                                wr_last,
  output logic [15:0]                         out_y_idx,
  output logic [15:0]                         out_f_idx,
  output logic                                busy,
  output logic                                tile_done,
  output logic                                err
);

  localparam int unsigned FIFO_NUM = SA_ROW_NUM * SA_COLUMN_NUM;
  localparam int unsigned PTR_W    = (OUT_BUF_DEPTH > 1) ? $clog2(OUT_BUF_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(OUT_BUF_DEPTH + 1);
  localparam int unsigned MAX_CH0  = SA_ROW_NUM * ROW_NUM_IN_SA;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]             state_q, state_d;
  logic                   mode_q;
  logic [ADR_W-1:0]       base_q;
  logic [3:0]             shift_q;
  logic [15:0]            oy_q, of_q, xofs_q, poy_q, pof_q, row_q, ch_q;
  logic                   err_q;

  // One-deep read pipe mirroring the FIFO's 1-cycle read latency.
  logic                   rd_v_q, rd_hi_q, rd_word_q, rd_last_q;
  logic [15:0]            rd_y_q, rd_f_q;
  logic [CONV_WORD_W-1:0] lo_q;

  logic [DDR_WORD_W-1:0]  buf_data_q [OUT_BUF_DEPTH];
  logic                   buf_last_q [OUT_BUF_DEPTH];
  logic [15:0]            buf_y_q    [OUT_BUF_DEPTH];
  logic [15:0]            buf_f_q    [OUT_BUF_DEPTH];
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic [CNT_W-1:0]       cnt_q;

  logic                   illegal, start_ok, push, buf_empty, bypass, pop_buf, store;
  logic                   head_last, accept_last, room, issue;
  logic [DDR_WORD_W-1:0]  push_data;
  logic [15:0]            ch_nxt;
  logic [31:0]            fifo_sel;
  logic                   unused_ox;

  assign unused_ox = ^cur_ox_start;

  assign illegal  = (mode > 4'd1) || (cur_poy > 16'(SA_COLUMN_NUM)) ||
                    (32'(cur_pof) > (mode[0] ? 2 * MAX_CH0 : MAX_CH0));
  assign start_ok = (state_q == IDLE) && start && !illegal;

  assign push      = rd_v_q && rd_word_q;
  assign push_data = mode_q  ? fifo_data :
                     rd_hi_q ? {fifo_data[CONV_WORD_W-1:0], lo_q} :
                               {{(DDR_WORD_W-CONV_WORD_W){1'b0}}, fifo_data[CONV_WORD_W-1:0]};

  // An empty buffer lets a completing word fall straight through to the port.
  assign buf_empty   = (cnt_q == '0);
  assign bypass      = buf_empty && push;
  assign wr_valid    = !buf_empty || push;
  assign pop_buf     = !buf_empty && wr_ready;
  assign store       = push && !(bypass && wr_ready);
  assign head_last   = buf_empty ? rd_last_q : buf_last_q[rptr_q];
  assign accept_last = wr_valid && wr_ready && head_last;

  assign wr_data   = !wr_valid ? '0 : (buf_empty ? push_data : buf_data_q[rptr_q]);
  assign wr_last   = wr_valid && head_last;
  assign out_y_idx = !wr_valid ? '0 : (buf_empty ? rd_y_q : buf_y_q[rptr_q]);
  assign out_f_idx = !wr_valid ? '0 : (buf_empty ? rd_f_q : buf_f_q[rptr_q]);

  // Occupancy after this cycle's pop plus the word landing now must leave room.
  assign room     = (int'(cnt_q) - int'(pop_buf) + int'(push)) < int'(OUT_BUF_DEPTH);
  assign issue    = (state_q == DATA) && (ch_q < pof_q) && room;
  assign ch_nxt   = ch_q + (mode_q ? 16'd2 : 16'd1);
  assign fifo_sel = 32'(row_q) * SA_ROW_NUM +
                    32'(ch_q) / (mode_q ? 2 * ROW_NUM_IN_SA : ROW_NUM_IN_SA);
  assign fifo_rds = issue ? (FIFO_NUM'(1) << fifo_sel) : '0;

  assign cmd_valid = (state_q == CMD);
  assign cmd_adr   = !cmd_valid ? '0 :
                     base_q + ((ADR_W'(oy_q) - ADR_W'(1) + ADR_W'(row_q)) << shift_q) +
                     ADR_W'(xofs_q) + ((ADR_W'(of_q) - ADR_W'(1)) >> 1);
  assign cmd_len   = !cmd_valid ? '0 : 16'((17'(pof_q) + 17'd1) >> 1);

  assign busy      = (state_q != IDLE);
  assign tile_done = (state_q == DONE);
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = ((cur_poy == '0) || (cur_pof == '0)) ? DONE : CMD;
      CMD:  if (cmd_ready) state_d = DATA;
      DATA: if (accept_last) state_d = (row_q + 16'd1 >= poy_q) ? DONE : CMD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      mode_q    <= 1'b0;
      base_q    <= '0;
      shift_q   <= '0;
      oy_q      <= '0;
      of_q      <= '0;
      xofs_q    <= '0;
      poy_q     <= '0;
      pof_q     <= '0;
      row_q     <= '0;
      ch_q      <= '0;
      rd_v_q    <= 1'b0;
      rd_hi_q   <= 1'b0;
      rd_word_q <= 1'b0;
      rd_last_q <= 1'b0;
      rd_y_q    <= '0;
      rd_f_q    <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && start && illegal;
      if ((state_q == IDLE) && start) begin
        mode_q  <= mode[0];
        base_q  <= layer_base_adr;
        shift_q <= row_adr_shift;
        oy_q    <= cur_oy_start;
        of_q    <= cur_of_start;
        xofs_q  <= x_word_ofs;
        poy_q   <= cur_poy;
        pof_q   <= cur_pof;
      end
      if (start_ok) begin
        row_q <= '0;
        ch_q  <= '0;
      end else if (issue) begin
        ch_q <= ch_nxt;
      end else if ((state_q == DATA) && (state_d == CMD)) begin
        row_q <= row_q + 16'd1;
        ch_q  <= '0;
      end
      rd_v_q    <= issue;
      rd_hi_q   <= !mode_q && ch_q[0];
      rd_word_q <= mode_q || ch_q[0] || (ch_q + 16'd1 >= pof_q);
      rd_last_q <= (ch_nxt >= pof_q);
      rd_y_q    <= oy_q + row_q;
      rd_f_q    <= of_q + (ch_q & 16'hFFFE);
      if (rd_v_q && !mode_q && !rd_hi_q) lo_q <= fifo_data[CONV_WORD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(OUT_BUF_DEPTH); i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
        buf_y_q[i]    <= '0;
        buf_f_q[i]    <= '0;
      end
    end else begin
      if (store) begin
        buf_data_q[wptr_q] <= push_data;
        buf_last_q[wptr_q] <= rd_last_q;
        buf_y_q[wptr_q]    <= rd_y_q;
        buf_f_q[wptr_q]    <= rd_f_q;
        wptr_q <= (wptr_q == PTR_W'(OUT_BUF_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop_buf) rptr_q <= (rptr_q == PTR_W'(OUT_BUF_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(store) - CNT_W'(pop_buf);
    end
  end

endmodule

// File: tb/tb_conv_store_ddr_stream_ctrl.sv
// Bench for conv_store_ddr_stream_ctrl: FIFO-grid model, tile-level reference model and
// scoreboard for commands and DDR words, plus directed corner cases and randomized tiles.
module tb_conv_store_ddr_stream_ctrl;
  localparam int NF = 12;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    mode = '0;
  logic [31:0]   layer_base_adr = '0;
  logic [3:0]    row_adr_shift = '0;
  logic [15:0]   cur_oy_start = '0, cur_ox_start = '0, cur_of_start = '0;
  logic [15:0]   x_word_ofs = '0, cur_poy = '0, cur_pof = '0;
  logic [NF-1:0] fifo_rds;
  logic [511:0]  fifo_data = '0;
  logic          cmd_valid, cmd_ready = 1'b0, wr_valid, wr_ready = 1'b0, wr_last;
  logic [31:0]   cmd_adr;
  logic [15:0]   cmd_len, out_y_idx, out_f_idx;
  logic [511:0]  wr_data;
  logic          busy, tile_done, err;

  conv_store_ddr_stream_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .layer_base_adr(layer_base_adr),
    .row_adr_shift(row_adr_shift), .cur_oy_start(cur_oy_start), .cur_ox_start(cur_ox_start),
    .cur_of_start(cur_of_start), .x_word_ofs(x_word_ofs), .cur_poy(cur_poy), .cur_pof(cur_pof),
    .fifo_rds(fifo_rds), .fifo_data(fifo_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .out_y_idx(out_y_idx), .out_f_idx(out_f_idx),
    .busy(busy), .tile_done(tile_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference queues
  logic [31:0]  exp_adr_q[$];
  logic [15:0]  exp_len_q[$];
  logic [511:0] exp_data_q[$];
  logic         exp_last_q[$];
  logic [15:0]  exp_y_q[$], exp_f_q[$];

  int  seed = 0, wr_pat = 0, cmd_pat = 0, tile_cyc = 0, cmd_wait = 0;
  int  ncyc = 0, hs_cnt = 0, words_seen = 0, words_exp = 0, done_cnt = 0;
  int  hs_cyc = -1, rd_cyc = -1, wv_cyc = -1, stall_len = 0, stall_rds = 0;
  int  rdcnt[NF];
  bit  mon_en = 1'b0, pend_v = 1'b0;
  int  pend_idx = 0;

  // Distinct content for the n-th read of FIFO f in the current tile.
  function automatic logic [511:0] gen(input int f, input int n);
    logic [511:0] v;
    for (int i = 0; i < 16; i++)
      v[i*32 +: 32] = 32'((seed + f * 7919 + n * 104729 + i * 31) * 32'h9E3779B1);
    return v;
  endfunction

  // FIFO grid: data for a strobe appears one cycle later.
  always @(posedge clk) begin
    if (pend_v) begin
      fifo_data <= gen(pend_idx, rdcnt[pend_idx]);
      rdcnt[pend_idx]++;
    end
  end

  always @(posedge clk) begin
    int phase;
    #1;
    tile_cyc++;
    phase = tile_cyc % 40;
    case (wr_pat)
      0: wr_ready = 1'b1;
      1: wr_ready = ($urandom_range(0, 3) != 0);
      default: wr_ready = (phase < 4) ? (phase == 0 || phase == 3) : !(phase >= 10 && phase < 30);
    endcase
    case (cmd_pat)
      0: cmd_ready = 1'b1;
      1: cmd_ready = ($urandom_range(0, 1) != 0);
      default: cmd_ready = (cmd_wait >= 10);
    endcase
  end

  always @(negedge clk) begin
    pend_v = (fifo_rds != '0);
    for (int i = 0; i < NF; i++) if (fifo_rds[i]) pend_idx = i;
    if (mon_en) begin
      ncyc++;
      if (fifo_rds != '0) begin
        check_eq("rds_onehot", 512'($onehot(fifo_rds)), 512'(1));
        if (rd_cyc < 0) rd_cyc = ncyc;
      end
      if (cmd_valid) begin
        check_eq("cmd_no_rds", 512'(fifo_rds), 512'(0));
        if (exp_adr_q.size() == 0) check_eq("cmd_unexpected", 512'(1), 512'(0));
        else begin
          check_eq("cmd_adr", 512'(cmd_adr), 512'(exp_adr_q[0]));
          check_eq("cmd_len", 512'(cmd_len), 512'(exp_len_q[0]));
          if (cmd_ready) begin
            void'(exp_adr_q.pop_front());
            void'(exp_len_q.pop_front());
            hs_cnt++;
            cmd_wait = 0;
            if (hs_cyc < 0) hs_cyc = ncyc;
          end else cmd_wait++;
        end
      end
      if (wr_valid) begin
        if (wv_cyc < 0) wv_cyc = ncyc;
        if (exp_data_q.size() == 0) check_eq("wr_unexpected", 512'(1), 512'(0));
        else begin
          check_eq("wr_data", wr_data, exp_data_q[0]);
          check_eq("wr_last", 512'(wr_last), 512'(exp_last_q[0]));
          check_eq("out_y_idx", 512'(out_y_idx), 512'(exp_y_q[0]));
          check_eq("out_f_idx", 512'(out_f_idx), 512'(exp_f_q[0]));
          if (wr_ready) begin
            void'(exp_data_q.pop_front());
            void'(exp_last_q.pop_front());
            void'(exp_y_q.pop_front());
            void'(exp_f_q.pop_front());
            words_seen++;
          end
        end
      end
      if (tile_done) done_cnt++;
      if (!wr_ready) begin
        stall_len++;
        if (fifo_rds != '0) stall_rds++;
      end else begin
        if (stall_len >= 15) check_eq("stall_rds_bound", 512'(stall_rds <= DEPTH), 512'(1));
        stall_len = 0;
        stall_rds = 0;
      end
    end
  end

  task automatic start_tile(input int m, input int poy, input int pof, input int oy,
                            input int of, input int shift, input logic [31:0] base,
                            input int xofs);
    int l;
    logic [511:0] v, d;
    l = (pof + 1) / 2;
    seed = int'($urandom);
    for (int r = 0; r < poy && pof > 0; r++) begin
      exp_adr_q.push_back(base + ((32'(oy) - 32'd1 + 32'(r)) << shift) + 32'(xofs) +
                          ((32'(of) - 32'd1) >> 1));
      exp_len_q.push_back(16'(l));
      for (int w = 0; w < l; w++) begin
        if (m == 1) d = gen(r * 4 + (2 * w) / 32, ((2 * w) % 32) / 2);
        else begin
          v = gen(r * 4 + (2 * w) / 16, (2 * w) % 16);
          d = '0;
          d[255:0] = v[255:0];
          if (2 * w + 1 < pof) begin
            v = gen(r * 4 + (2 * w + 1) / 16, (2 * w + 1) % 16);
            d[511:256] = v[255:0];
          end
        end
        exp_data_q.push_back(d);
        exp_last_q.push_back(w == l - 1);
        exp_y_q.push_back(16'(oy + r));
        exp_f_q.push_back(16'(of + 2 * w));
      end
    end
    words_exp = (pof > 0) ? poy * l : 0;
    for (int i = 0; i < NF; i++) rdcnt[i] = 0;
    hs_cnt = 0; words_seen = 0; done_cnt = 0; cmd_wait = 0;
    hs_cyc = -1; rd_cyc = -1; wv_cyc = -1;
    @(posedge clk); #2;
    tile_cyc = 0;
    mode = 4'(m); cur_poy = 16'(poy); cur_pof = 16'(pof); cur_oy_start = 16'(oy);
    cur_of_start = 16'(of); row_adr_shift = 4'(shift); layer_base_adr = base;
    x_word_ofs = 16'(xofs); cur_ox_start = 16'($urandom_range(1, 99)); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    // Inputs are only sampled at start; scramble them to catch late sampling.
    {mode, cur_poy, cur_pof, cur_oy_start, cur_of_start} = {4'd0, 16'($urandom), 16'($urandom),
                                                             16'($urandom), 16'($urandom)};
    layer_base_adr = $urandom; x_word_ofs = 16'($urandom); row_adr_shift = 4'($urandom);
  endtask

  task automatic wait_tile(input string tag);
    for (int i = 0; i < 6000 && done_cnt == 0; i++) @(posedge clk);
    check_eq({tag, "_done_seen"}, 512'(done_cnt > 0), 512'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_done_once"}, 512'(done_cnt), 512'(1));
    check_eq({tag, "_words"}, 512'(words_seen), 512'(words_exp));
    check_eq({tag, "_cmds_left"}, 512'(exp_adr_q.size()), 512'(0));
    check_eq({tag, "_words_left"}, 512'(exp_data_q.size()), 512'(0));
    check_eq({tag, "_idle"}, 512'(busy), 512'(0));
  endtask

  task automatic illegal_start(input int m, input int poy, input int pof);
    @(posedge clk); #2;
    mode = 4'(m); cur_poy = 16'(poy); cur_pof = 16'(pof); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    check_eq("ill_err", 512'(err), 512'(1));
    check_eq("ill_busy", 512'(busy), 512'(0));
    repeat (4) begin
      @(negedge clk);
      check_eq("ill_quiet", 512'({busy, cmd_valid, err, tile_done}), 512'(0));
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_ctl"}, 512'({busy, cmd_valid, wr_valid, wr_last, tile_done, err}), 512'(0));
    check_eq({tag, "_rds"}, 512'(fifo_rds), 512'(0));
    check_eq({tag, "_cmd"}, 512'({cmd_adr, cmd_len}), 512'(0));
    check_eq({tag, "_wr"}, wr_data, 512'(0));
    check_eq({tag, "_idx"}, 512'({out_y_idx, out_f_idx}), 512'(0));
  endtask

  initial begin
    int m, pof;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs_zero("reset");
    reset = 1'b1;
    mon_en = 1'b1;

    // Mode 1, three rows of 64 channels at full rate.
    wr_pat = 0; cmd_pat = 0;
    start_tile(1, 3, 64, 1, 1, 4, 32'h1000, 0);
    wait_tile("m1_full");
    check_eq("m1_lat_rd", 512'(rd_cyc - hs_cyc), 512'(1));
    check_eq("m1_lat_wv", 512'(wv_cyc - hs_cyc), 512'(2));

    // Mode 0, odd channel tail.
    start_tile(0, 1, 5, 1, 1, 4, 32'h1000, 0);
    wait_tile("m0_tail");
    check_eq("m0_fifo0_reads", 512'(rdcnt[0]), 512'(5));
    check_eq("m0_fifo1_reads", 512'(rdcnt[1]), 512'(0));
    check_eq("m0_lat_wv", 512'(wv_cyc - hs_cyc), 512'(3));

    // Write backpressure with a long stall.
    wr_pat = 2;
    start_tile(1, 3, 64, 2, 3, 5, 32'h2000, 7);
    wait_tile("m1_stall");
    start_tile(0, 2, 33, 4, 2, 3, 32'h40, 1);
    wait_tile("m0_stall");

    // Command backpressure for 10 cycles per row.
    wr_pat = 0; cmd_pat = 2;
    start_tile(1, 2, 20, 1, 5, 4, 32'h3000, 2);
    wait_tile("cmd_hold");
    cmd_pat = 0;

    illegal_start(2, 1, 4);
    illegal_start(1, 4, 4);
    illegal_start(0, 1, 80);

    start_tile(1, 0, 8, 1, 1, 0, 32'h0, 0);
    wait_tile("poy_zero");
    start_tile(0, 2, 0, 1, 1, 0, 32'h0, 0);
    wait_tile("pof_zero");

    for (int t = 0; t < 10; t++) begin
      m = int'($urandom_range(0, 1));
      pof = int'($urandom_range(1, (m == 1) ? 128 : 64));
      wr_pat = int'($urandom_range(0, 1));
      cmd_pat = int'($urandom_range(0, 1));
      start_tile(m, int'($urandom_range(1, 3)), pof, int'($urandom_range(1, 200)),
                 int'($urandom_range(1, 60)), int'($urandom_range(0, 15)), $urandom,
                 int'($urandom_range(0, 1000)));
      wait_tile("rand");
    end

    // Reset in the middle of the second row's burst.
    wr_pat = 0; cmd_pat = 0;
    start_tile(1, 3, 64, 1, 1, 4, 32'h1000, 0);
    for (int i = 0; i < 2000 && !(hs_cnt >= 2 && words_seen >= 40); i++) @(posedge clk);
    check_eq("rst_mid_reached", 512'(hs_cnt >= 2 && words_seen >= 40), 512'(1));
    @(posedge clk); #3;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_outs_zero("rst_mid");
    check_eq("rst_no_done", 512'(done_cnt), 512'(0));
    exp_adr_q.delete(); exp_len_q.delete(); exp_data_q.delete();
    exp_last_q.delete(); exp_y_q.delete(); exp_f_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    start_tile(1, 3, 64, 1, 1, 4, 32'h1000, 0);
    wait_tile("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
